// File: rtl/accum_poll_pkg.sv
// Shared types and constants for the accum_poll_master Avalon-MM PIO poller.
package accum_poll_pkg;

  localparam int unsigned AVM_ADDR_W = 2;
  localparam int unsigned AVM_DATA_W = 32;
  // Wide enough to hold READ_LATENCY-1 for latencies 1..4.
  localparam int unsigned LAT_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LAT  = 2'd2
  } poll_state_e;

endpackage

// File: rtl/accum_poll_master_prescaler.sv
// Poll-rate prescaler: free-running divider that raises a pending request
// every POLL_DIV cycles and flags overrun if the previous one was never taken.
module poll_prescaler
  import accum_poll_pkg::*;
#(
  parameter int unsigned POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_enable,
  input  logic i_take,
  output logic o_pending,
  output logic o_overrun
);

  localparam int unsigned DIV_W = $clog2(POLL_DIV);
  localparam logic [DIV_W-1:0] TERM = DIV_W'(POLL_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_overrun;
  logic             w_tick;

  assign w_tick = i_enable && (r_cnt == TERM);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (!i_enable || w_tick) r_cnt <= '0;
      else                     r_cnt <= r_cnt + 1'b1;

      // A tick in the same cycle the FSM takes the request re-arms pending.
      if (!i_enable)   r_pending <= 1'b0;
      else if (w_tick) r_pending <= 1'b1;
      else if (i_take) r_pending <= 1'b0;

      if (w_tick && r_pending && !i_take) r_overrun <= 1'b1;
    end
  end

  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/accum_poll_master.sv
// Avalon-MM read master polling bit 0 of a PIO slave; produces level,
// edge pulses and a wrapping sample counter for the game-logic FSMs.
module accum_poll_master
  import accum_poll_pkg::*;
#(
  parameter int unsigned POLL_DIV     = 50000,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned SLAVE_ADDR   = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  output logic                  level,
  output logic                  sample_valid,
  output logic                  rise,
  output logic                  fall,
  output logic [CNT_W-1:0]      sample_count,
  output logic                  overrun
);

  poll_state_e      r_state;
  poll_state_e      w_state_nxt;
  logic [LAT_W-1:0] r_lat_cnt;
  logic             w_pending;
  logic             w_take;
  logic             w_accept;
  logic             w_capture;
  logic             w_bit;
  logic             r_level;
  logic             r_primed;
  logic             r_sample_valid;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_count;
  logic             w_unused_rdata;

  poll_prescaler #(
    .POLL_DIV(POLL_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_enable (enable),
    .i_take   (w_take),
    .o_pending(w_pending),
    .o_overrun(overrun)
  );

  assign w_accept       = (r_state == REQ) && !avm_waitrequest;
  assign w_bit          = avm_readdata[0];
  assign w_unused_rdata = ^avm_readdata[AVM_DATA_W-1:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pending) begin
          w_take      = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (!avm_waitrequest) w_state_nxt = LAT;
      end
      LAT: begin
        if (r_lat_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lat_cnt <= '0;
    end else if (w_accept) begin
      r_lat_cnt <= LAT_W'(READ_LATENCY - 1);
    end else if ((r_state == LAT) && (r_lat_cnt != '0)) begin
      r_lat_cnt <= r_lat_cnt - 1'b1;
    end
  end

  // Edge pulses compare against the previous sample; suppressed until primed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level        <= 1'b0;
      r_primed       <= 1'b0;
      r_sample_valid <= 1'b0;
      r_rise         <= 1'b0;
      r_fall         <= 1'b0;
      r_count        <= '0;
    end else begin
      r_sample_valid <= w_capture;
      r_rise         <= w_capture && r_primed && !r_level && w_bit;
      r_fall         <= w_capture && r_primed && r_level && !w_bit;
      if (w_capture) begin
        r_level  <= w_bit;
        r_primed <= 1'b1;
        r_count  <= r_count + 1'b1;
      end
    end
  end

  assign avm_address  = AVM_ADDR_W'(SLAVE_ADDR);
  assign avm_read     = (r_state == REQ);
  assign level        = r_level;
  assign sample_valid = r_sample_valid;
  assign rise         = r_rise;
  assign fall         = r_fall;
  assign sample_count = r_count;

endmodule

// File: tb/tb_accum_poll_master.sv
// Bench for accum_poll_master: two instances (fast-poll and overrun configs)
// checked every cycle against a transaction-level model of the poller.
module tb_accum_poll_master;

  localparam int unsigned PD_A = 8;
  localparam int unsigned RL_A = 1;
  localparam int unsigned AD_A = 2;
  localparam int unsigned PD_B = 2;
  localparam int unsigned RL_B = 3;
  localparam int unsigned AD_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        en    [2];
  logic        wreq  [2];
  logic [31:0] rdata [2];

  logic [1:0]  addr_a, addr_b;
  logic        rd_a, rd_b, lvl_a, lvl_b, sv_a, sv_b;
  logic        rise_a, rise_b, fall_a, fall_b, ovr_a, ovr_b;
  logic [15:0] cnt_a, cnt_b;

  accum_poll_master #(
    .POLL_DIV(PD_A), .READ_LATENCY(RL_A), .SLAVE_ADDR(AD_A), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en[0]),
    .avm_address(addr_a), .avm_read(rd_a), .avm_waitrequest(wreq[0]),
    .avm_readdata(rdata[0]), .level(lvl_a), .sample_valid(sv_a),
    .rise(rise_a), .fall(fall_a), .sample_count(cnt_a), .overrun(ovr_a)
  );

  accum_poll_master #(
    .POLL_DIV(PD_B), .READ_LATENCY(RL_B), .SLAVE_ADDR(AD_B), .CNT_W(16)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en[1]),
    .avm_address(addr_b), .avm_read(rd_b), .avm_waitrequest(wreq[1]),
    .avm_readdata(rdata[1]), .level(lvl_b), .sample_valid(sv_b),
    .rise(rise_b), .fall(fall_b), .sample_count(cnt_b), .overrun(ovr_b)
  );

  int errors = 0;
  int checks = 0;

  int unsigned pd_of [2];
  int unsigned rl_of [2];
  int unsigned ad_of [2];

  // Stimulus controls: rd_mode 0 = fixed bit 0 with random upper bits, 1 = random;
  // wr_mode 0 = never stall, 1 = random stalls of at most 3 cycles, 2 = stall.
  int   rd_mode   [2];
  int   wr_mode   [2];
  int   wr_run    [2];
  logic fixed_bit [2];

  // Reference model: one read in flight, capture RL cycles after acceptance,
  // results visible the cycle after capture.
  int          cyc = 0;
  int          cap_at    [2];
  int          out_at    [2];
  int          prev_rise [2];
  logic        cap_bit   [2];
  logic        m_lvl     [2];
  logic        m_primed  [2];
  logic [15:0] m_cnt     [2];
  logic        prev_read [2];
  logic        prev_stall[2];

  logic        last_read [2];
  logic        last_sv   [2];
  logic        last_lvl  [2];
  logic        last_rise [2];
  logic        last_fall [2];
  logic        last_ovr  [2];
  logic        last_acc  [2];
  logic [15:0] last_cnt  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset(input int i);
    cap_at[i]     = -1;
    out_at[i]     = -1;
    prev_rise[i]  = -1;
    cap_bit[i]    = 1'b0;
    m_lvl[i]      = 1'b0;
    m_primed[i]   = 1'b0;
    m_cnt[i]      = '0;
    prev_read[i]  = 1'b0;
    prev_stall[i] = 1'b0;
  endtask

  task automatic monitor();
    logic        o_rd [2], o_sv [2], o_lv [2], o_ri [2], o_fa [2], o_ov [2];
    logic [1:0]  o_ad [2];
    logic [15:0] o_ct [2];
    logic        e_ri, e_fa;
    o_rd[0] = rd_a;   o_rd[1] = rd_b;
    o_sv[0] = sv_a;   o_sv[1] = sv_b;
    o_lv[0] = lvl_a;  o_lv[1] = lvl_b;
    o_ri[0] = rise_a; o_ri[1] = rise_b;
    o_fa[0] = fall_a; o_fa[1] = fall_b;
    o_ov[0] = ovr_a;  o_ov[1] = ovr_b;
    o_ad[0] = addr_a; o_ad[1] = addr_b;
    o_ct[0] = cnt_a;  o_ct[1] = cnt_b;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      last_read[i] = o_rd[i];
      last_sv[i]   = o_sv[i];
      last_lvl[i]  = o_lv[i];
      last_rise[i] = o_ri[i];
      last_fall[i] = o_fa[i];
      last_ovr[i]  = o_ov[i];
      last_cnt[i]  = o_ct[i];
      last_acc[i]  = 1'b0;
      if (!reset_n) begin
        model_reset(i);
        check("in_reset_read", 32'(o_rd[i]), 32'(0));
        check("in_reset_valid", 32'(o_sv[i]), 32'(0));
        continue;
      end
      check("address", 32'(o_ad[i]), 32'(ad_of[i]));
      if (cap_at[i] != -1 || out_at[i] == cyc) check("read_while_busy", 32'(o_rd[i]), 32'(0));
      if (prev_stall[i]) check("read_held_in_stall", 32'(o_rd[i]), 32'(1));
      e_ri = 1'b0;
      e_fa = 1'b0;
      if (out_at[i] == cyc) begin
        e_ri        = m_primed[i] && !m_lvl[i] && cap_bit[i];
        e_fa        = m_primed[i] && m_lvl[i] && !cap_bit[i];
        m_lvl[i]    = cap_bit[i];
        m_primed[i] = 1'b1;
        m_cnt[i]    = m_cnt[i] + 16'd1;
        out_at[i]   = -1;
        check("sample_valid", 32'(o_sv[i]), 32'(1));
      end else begin
        check("sample_valid", 32'(o_sv[i]), 32'(0));
      end
      check("level", 32'(o_lv[i]), 32'(m_lvl[i]));
      check("rise", 32'(o_ri[i]), 32'(e_ri));
      check("fall", 32'(o_fa[i]), 32'(e_fa));
      check("sample_count", 32'(o_ct[i]), 32'(m_cnt[i]));
      if (i == 0) check("overrun_a", 32'(o_ov[i]), 32'(0));
      if (cap_at[i] == cyc) begin
        cap_bit[i] = rdata[i][0];
        out_at[i]  = cyc + 1;
        cap_at[i]  = -1;
      end
      if (o_rd[i] && !wreq[i]) begin
        cap_at[i]   = cyc + int'(rl_of[i]);
        last_acc[i] = 1'b1;
      end
      if (i == 0) begin
        if (!en[i]) begin
          prev_rise[i] = -1;
        end else if (o_rd[i] && !prev_read[i]) begin
          if (prev_rise[i] != -1) check("poll_interval", 32'(cyc - prev_rise[i]), 32'(pd_of[i]));
          prev_rise[i] = cyc;
        end
      end
      prev_read[i]  = o_rd[i];
      prev_stall[i] = o_rd[i] && wreq[i];
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      rdata[i] = $urandom();
      if (rd_mode[i] == 0) rdata[i][0] = fixed_bit[i];
      case (wr_mode[i])
        0:       wreq[i] = 1'b0;
        1:       wreq[i] = (wr_run[i] < 3) && ($urandom_range(0, 2) == 0);
        default: wreq[i] = 1'b1;
      endcase
      wr_run[i] = wreq[i] ? wr_run[i] + 1 : 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  // kind: 0 = avm_read seen, 1 = sample_valid seen, 2 = command accepted.
  task automatic wait_for(input int kind, input int inst, input int budget,
                          input string tag, output int n);
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      step();
      n++;
      case (kind)
        0:       seen = last_read[inst];
        1:       seen = last_sv[inst];
        default: seen = last_acc[inst];
      endcase
    end
    check({tag, "_seen"}, 32'(seen), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seq_bit  [4];
    logic seq_rise [4];
    logic seq_fall [4];
    int   n;
    seq_bit  = '{1'b0, 1'b1, 1'b1, 1'b0};
    seq_rise = '{1'b0, 1'b1, 1'b0, 1'b0};
    seq_fall = '{1'b0, 1'b0, 1'b0, 1'b1};
    pd_of[0] = PD_A; rl_of[0] = RL_A; ad_of[0] = AD_A;
    pd_of[1] = PD_B; rl_of[1] = RL_B; ad_of[1] = AD_B;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; rd_mode[i] = 0; wr_mode[i] = 0; wr_run[i] = 0; fixed_bit[i] = 1'b0;
      model_reset(i);
    end

    // Power-on reset and idle values.
    reset_n = 1'b0;
    drive();
    repeat (3) step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      check("rst_read", 32'(last_read[i]), 32'(0));
      check("rst_level", 32'(last_lvl[i]), 32'(0));
      check("rst_valid", 32'(last_sv[i]), 32'(0));
      check("rst_rise", 32'(last_rise[i]), 32'(0));
      check("rst_fall", 32'(last_fall[i]), 32'(0));
      check("rst_count", 32'(last_cnt[i]), 32'(0));
      check("rst_overrun", 32'(last_ovr[i]), 32'(0));
    end

    // Reset asserted mid-REQ while the slave stalls.
    wr_mode[0] = 2;
    en[0]      = 1'b1;
    wait_for(0, 0, 40, "first_read", n);
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_read", 32'(rd_a), 32'(0));
    check("async_rst_level", 32'(lvl_a), 32'(0));
    check("async_rst_valid", 32'(sv_a), 32'(0));
    check("async_rst_rise", 32'(rise_a), 32'(0));
    check("async_rst_fall", 32'(fall_a), 32'(0));
    check("async_rst_count", 32'(cnt_a), 32'(0));
    repeat (3) step();
    wr_mode[0] = 0;
    drive();
    reset_n = 1'b1;

    // Four polls reading 0,1,1,0: no pulse on the first, rise on 2, fall on 4.
    for (int k = 0; k < 4; k++) begin
      fixed_bit[0] = seq_bit[k];
      wait_for(1, 0, 40, "poll_sample", n);
      check("poll_level", 32'(last_lvl[0]), 32'(seq_bit[k]));
      check("poll_rise", 32'(last_rise[0]), 32'(seq_rise[k]));
      check("poll_fall", 32'(last_fall[0]), 32'(seq_fall[k]));
      check("poll_count", 32'(last_cnt[0]), 32'(k + 1));
    end

    // Overrun-prone instance runs randomly from here on.
    rd_mode[1] = 1;
    wr_mode[1] = 1;
    en[1]      = 1'b1;

    // Five-cycle stall: read and address held, capture RL cycles after release.
    wr_mode[0] = 2;
    wait_for(0, 0, 40, "stall_read", n);
    repeat (3) begin
      step();
      check("stall_read_held", 32'(last_read[0]), 32'(1));
    end
    wr_mode[0] = 0;
    wait_for(1, 0, 20, "stall_sample", n);
    check("stall_capture_latency", 32'(n), 32'(RL_A + 3));

    // Random data and bounded random stalls on both instances.
    rd_mode[0] = 1;
    wr_mode[0] = 1;
    repeat (400) step();
    check("overrun_b_set", 32'(last_ovr[1]), 32'(1));
    check("overrun_a_clear", 32'(last_ovr[0]), 32'(0));

    // Disable during LAT: in-flight sample still lands, then no reads.
    wr_mode[0] = 0;
    wait_for(2, 0, 40, "accept_before_disable", n);
    en[0] = 1'b0;
    wait_for(1, 0, 10, "disable_sample", n);
    check("disable_capture_latency", 32'(n), 32'(RL_A + 1));
    repeat (20) begin
      step();
      check("no_read_while_disabled", 32'(last_read[0]), 32'(0));
    end
    en[0] = 1'b1;
    wait_for(0, 0, 40, "reenable_read", n);
    check("reenable_first_read", 32'(n), 32'(PD_A + 2));

    wr_mode[0] = 1;
    repeat (150) step();
    check("overrun_b_sticky", 32'(last_ovr[1]), 32'(1));
    check("overrun_a_final", 32'(last_ovr[0]), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accum_poll_master.md
Name: accum_poll_master

Overview:
- Avalon-MM read master that polls a 1-bit input-PIO slave on the SoC fabric at a fixed rate.
- Samples bit 0 of the slave's readdata.
- Turns each sample into a level, rise/fall pulses and a sample counter for the game-logic FSMs.
- Sits between the PIO slave's s1 port and the tank control logic, so no Nios software polling loop is needed.

Parameters:
- POLL_DIV, 50000, clk cycles between poll requests (>=2)
- READ_LATENCY, 1, fixed slave read latency in cycles after command acceptance (1..4)
- SLAVE_ADDR, 0, 2-bit word address driven on every read
- CNT_W, 16, width of sample_count

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  polling enable
- avm_address  out  2  Avalon address (constant SLAVE_ADDR)
- avm_read  out  1  Avalon read command
- avm_waitrequest  in  1  slave stall; command accepted when avm_read & !avm_waitrequest
- avm_readdata  in  32  slave read data; only bit 0 used
- level  out  1  last sampled bit
- sample_valid  out  1  1-cycle pulse when level is updated
- rise  out  1  1-cycle pulse, 0->1 between consecutive samples
- fall  out  1  1-cycle pulse, 1->0 between consecutive samples
- sample_count  out  CNT_W  completed samples, wraps
- overrun  out  1  sticky: a poll tick arrived while a request was already pending

Behaviour:
- Clock/reset: single clock clk; reset_n is asynchronous and active-low. All state is cleared on reset assertion regardless of clk.
- Reset values: avm_read=0, level=0, sample_valid=0, rise=0, fall=0, sample_count=0, overrun=0, FSM=IDLE, prescaler=0, pending=0, primed=0. avm_address is always SLAVE_ADDR.
- Prescaler:
  - While enable=1, counts 0..POLL_DIV-1 and wraps.
  - On the terminal count it emits tick. If pending is already 1 at that point, it sets overrun instead.
  - While enable=0, the prescaler is held at 0 and pending is cleared.
- FSM:
  - IDLE: if pending, go to REQ and clear pending.
  - REQ: avm_read=1. Hold it, with avm_address stable, until !avm_waitrequest. On acceptance go to LAT and load lat_cnt=READ_LATENCY-1.
  - LAT: decrement lat_cnt each cycle. In the cycle lat_cnt==0, avm_readdata is valid; capture bit 0 at that edge and go to IDLE.
- Timing for READ_LATENCY=1: acceptance edge at cycle T, capture at edge T+1. Outputs (level, pulses, count) are visible in cycle T+2.
- Disabling mid-transaction: if enable drops in REQ or LAT, the transaction still completes and is captured. avm_read is never withdrawn before acceptance.
- Capture:
  - sample_valid=1 for one cycle; level=d; sample_count increments modulo 2^CNT_W.
  - rise=primed & !level_old & d; fall=primed & level_old & !d. Then primed=1.
  - The first sample after reset never pulses rise or fall.
- Simultaneous events: a tick in the same cycle the FSM leaves IDLE sets pending again. It does not set overrun, because pending was cleared that cycle.
- Overrun clears only on reset.
- Throughput: minimum poll interval is READ_LATENCY+2 cycles. Faster ticks accumulate overrun, never a queue.

Decomposition:
- Shared package accum_poll_pkg holds:
  - FSM state enum (IDLE, REQ, LAT)
  - Avalon address width constant (2)
  - data width constant (32)
- One sub-module is natural: poll_prescaler (counter plus tick/pending/overrun logic). FSM and edge logic stay in the top level.

Test Plan:
- Reset mid-REQ, with reset_n low for 3 cycles while avm_waitrequest=1 -> avm_read=0 immediately (async), all outputs 0, no pulse after release until the first capture.
- POLL_DIV=8, READ_LATENCY=1, waitrequest=0, readdata=0 -> avm_read high 1 cycle every 8. First sample: sample_valid=1, level=0, rise=fall=0, sample_count=1.
- Input bit 0→1→1→0 over four polls (readdata=0,1,1,0) -> rise on poll 2 only, fall on poll 4 only, sample_count=4.
- waitrequest held high 5 cycles after avm_read asserts -> avm_read and avm_address stable throughout; capture exactly READ_LATENCY cycles after waitrequest drops.
- POLL_DIV=2, READ_LATENCY=3 -> overrun=1 and stays 1. Sample captures continue, one per completed transaction.
- Enable dropped during LAT -> in-flight sample is still captured. No further avm_read while enable=0. Re-enable -> first read POLL_DIV cycles later.
